// File: rtl/bitstream_reader_pkg.sv
// Shared types and constants for the AV1 bitstream reader.
// Build option BITSTREAM_READER_INVERT_EN selects inverted-dif byte storage with a ones pad.
package bitstream_reader_pkg;

  localparam int BR_DEF_WINDOW_WIDTH    = 32;
  localparam int BR_DEF_BITSTREAM_WIDTH = 8;
  localparam int BR_DEF_D_SIZE          = 5;
  localparam int BR_DEF_MIN_BITS        = 16;
  localparam int BR_CNT_WIDTH           = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } br_state_t;

`ifdef BITSTREAM_READER_INVERT_EN
  localparam logic BR_PAD = 1'b1;
`else
  localparam logic BR_PAD = 1'b0;
`endif

  // Mask with the low 'amount' bits set; used to shift the pad value into the window.
  function automatic logic [BR_DEF_WINDOW_WIDTH-1:0] br_low_mask(input logic [BR_DEF_D_SIZE-1:0] amount);
    br_low_mask = ~({BR_DEF_WINDOW_WIDTH{1'b1}} << amount);
  endfunction

endpackage

// File: rtl/bitstream_reader_byte_inserter.sv
// Combinational window update: shift left by d (pad shifted in, count saturating at 0),
// then merge one byte directly below the remaining real bits. No state, no backpressure.
module byte_inserter
  import bitstream_reader_pkg::*;
#(
  parameter int W  = BR_DEF_WINDOW_WIDTH,
  parameter int BW = BR_DEF_BITSTREAM_WIDTH,
  parameter int DS = BR_DEF_D_SIZE,
  parameter int CW = BR_CNT_WIDTH
) (
  input  logic [W-1:0]  window,
  input  logic [CW-1:0] cnt,
  input  logic [DS-1:0] shift,
  input  logic [BW-1:0] data,
  input  logic          insert,
  output logic [W-1:0]  window_next,
  output logic [CW-1:0] cnt_next
);

  logic [W-1:0]  pad_fill;
  logic [W-1:0]  shifted;
  logic [W-1:0]  byte_field;
  logic [W-1:0]  byte_mask;
  logic [BW-1:0] stored;
  logic [CW-1:0] cnt_shifted;
  logic [CW-1:0] offset;

  always_comb begin
    pad_fill    = BR_PAD ? ~({W{1'b1}} << shift) : '0;
    shifted     = (window << shift) | pad_fill;
    cnt_shifted = (cnt >= CW'(shift)) ? (cnt - CW'(shift)) : '0;

    // The byte lands right under the surviving real bits; the caller guarantees it fits.
    stored     = data ^ {BW{BR_PAD}};
    offset     = CW'(W - BW) - cnt_shifted;
    byte_field = {{(W-BW){1'b0}}, stored} << offset;
    byte_mask  = {{(W-BW){1'b0}}, {BW{1'b1}}} << offset;

    window_next = shifted;
    cnt_next    = cnt_shifted;
    if (insert) begin
      window_next = (shifted & ~byte_mask) | byte_field;
      cnt_next    = cnt_shifted + CW'(BW);
    end
  end

endmodule

// File: rtl/bitstream_reader.sv
// AV1 arithmetic-decoder bit window: byte-per-cycle fill, same-cycle consume, results visible
// right after the edge; ready drops when full, in DRAIN, flush or reset. Option: BITSTREAM_READER_INVERT_EN.
module bitstream_reader
  import bitstream_reader_pkg::*;
#(
  parameter int BR_WINDOW_WIDTH    = BR_DEF_WINDOW_WIDTH,
  parameter int BR_BITSTREAM_WIDTH = BR_DEF_BITSTREAM_WIDTH,
  parameter int BR_D_SIZE          = BR_DEF_D_SIZE,
  parameter int BR_MIN_BITS        = BR_DEF_MIN_BITS
) (
  input  logic                          br_clk,
  input  logic                          br_reset_n,
  input  logic                          br_flush,
  input  logic [BR_BITSTREAM_WIDTH-1:0] in_byte,
  input  logic                          in_byte_valid,
  input  logic                          in_byte_last,
  output logic                          in_byte_ready,
  input  logic                          in_consume,
  input  logic [BR_D_SIZE-1:0]          in_consume_bits,
  output logic [BR_WINDOW_WIDTH-1:0]    out_window,
  output logic                          out_window_valid,
  output logic [BR_CNT_WIDTH-1:0]       out_cnt,
  output logic                          out_eos,
  output logic                          out_overrun
);

  localparam int W  = BR_WINDOW_WIDTH;
  localparam int CW = BR_CNT_WIDTH;

  br_state_t              state;
  logic [W-1:0]           window;
  logic [CW-1:0]          cnt;
  logic                   eos;
  logic                   overrun;

  logic                   window_valid;
  logic                   handshake;
  logic                   consume_bad;
  logic                   consume_ok;
  logic [BR_D_SIZE-1:0]   shift_amt;
  logic [W-1:0]           window_next;
  logic [CW-1:0]          cnt_next;

  assign window_valid  = (cnt >= CW'(BR_MIN_BITS)) || (state == ST_DRAIN);
  assign in_byte_ready = br_reset_n && !br_flush && (state != ST_DRAIN)
                         && (cnt <= CW'(W - BR_BITSTREAM_WIDTH));
  assign handshake     = in_byte_valid && in_byte_ready;

  // An illegal consume is dropped entirely; a byte in the same cycle still goes in.
  assign consume_bad = in_consume && (!window_valid || (in_consume_bits > BR_D_SIZE'(BR_MIN_BITS)));
  assign consume_ok  = in_consume && !consume_bad;
  assign shift_amt   = consume_ok ? in_consume_bits : '0;

  byte_inserter #(
    .W  (W),
    .BW (BR_BITSTREAM_WIDTH),
    .DS (BR_D_SIZE),
    .CW (CW)
  ) u_byte_inserter (
    .window      (window),
    .cnt         (cnt),
    .shift       (shift_amt),
    .data        (in_byte),
    .insert      (handshake),
    .window_next (window_next),
    .cnt_next    (cnt_next)
  );

  always_ff @(posedge br_clk or negedge br_reset_n) begin
    if (!br_reset_n) begin
      state   <= ST_IDLE;
      window  <= {W{BR_PAD}};
      cnt     <= '0;
      eos     <= 1'b0;
      overrun <= 1'b0;
    end else if (br_flush) begin
      state   <= ST_IDLE;
      window  <= {W{BR_PAD}};
      cnt     <= '0;
      eos     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      window <= window_next;
      cnt    <= cnt_next;
      if (consume_bad) begin
        overrun <= 1'b1;
      end
      if (handshake) begin
        if (in_byte_last) begin
          state <= ST_DRAIN;
          eos   <= 1'b1;
        end else if (state == ST_IDLE) begin
          state <= ST_FILL;
        end
      end
    end
  end

  assign out_window       = window;
  assign out_window_valid = window_valid;
  assign out_cnt          = cnt;
  assign out_eos          = eos;
  assign out_overrun      = overrun;

endmodule

// File: tb/tb_bitstream_reader.sv
// Table-driven scoreboard bench for bitstream_reader; expected windows are written in
// zero-pad form and converted to the inverted form when BITSTREAM_READER_INVERT_EN is set.
module tb_bitstream_reader;

`ifdef BITSTREAM_READER_INVERT_EN
  localparam logic [31:0] PADW = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] PADW = 32'h0000_0000;
`endif

  logic        br_clk = 1'b0;
  logic        br_reset_n = 1'b0;
  logic        br_flush = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_byte_valid = 1'b0;
  logic        in_byte_last = 1'b0;
  logic        in_byte_ready;
  logic        in_consume = 1'b0;
  logic [4:0]  in_consume_bits = 5'd0;
  logic [31:0] out_window;
  logic        out_window_valid;
  logic [5:0]  out_cnt;
  logic        out_eos;
  logic        out_overrun;

  bitstream_reader dut (
    .br_clk           (br_clk),
    .br_reset_n       (br_reset_n),
    .br_flush         (br_flush),
    .in_byte          (in_byte),
    .in_byte_valid    (in_byte_valid),
    .in_byte_last     (in_byte_last),
    .in_byte_ready    (in_byte_ready),
    .in_consume       (in_consume),
    .in_consume_bits  (in_consume_bits),
    .out_window       (out_window),
    .out_window_valid (out_window_valid),
    .out_cnt          (out_cnt),
    .out_eos          (out_eos),
    .out_overrun      (out_overrun)
  );

  always #5 br_clk = ~br_clk;

  typedef struct {
    logic        flush;
    logic        vld;
    logic [7:0]  b;
    logic        last;
    logic        cons;
    logic [4:0]  d;
    logic        rdy;
    logic [31:0] win;
    logic [5:0]  cnt;
    logic        wv;
    logic        eos;
    logic        ovr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic flush, input logic vld, input logic [7:0] b,
                              input logic last, input logic cons, input logic [4:0] d,
                              input logic rdy, input logic [31:0] win, input logic [5:0] cnt,
                              input logic wv, input logic eos, input logic ovr);
    vec_t v;
    v.flush = flush; v.vld = vld; v.b = b; v.last = last; v.cons = cons; v.d = d;
    v.rdy = rdy; v.win = win ^ PADW; v.cnt = cnt; v.wv = wv; v.eos = eos; v.ovr = ovr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    br_flush = 1'b0; in_byte_valid = 1'b0; in_byte = 8'h00; in_byte_last = 1'b0;
    in_consume = 1'b0; in_consume_bits = 5'd0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    @(negedge br_clk);
    br_flush = v.flush; in_byte_valid = v.vld; in_byte = v.b; in_byte_last = v.last;
    in_consume = v.cons; in_consume_bits = v.d;
    sb.push_back(v);
    @(posedge br_clk);
    #1;
    idle_inputs();
    #1;
    e = sb.pop_front();
    check($sformatf("v%0d.win", idx), out_window, e.win);
    check($sformatf("v%0d.cnt", idx), 32'(out_cnt), 32'(e.cnt));
    check($sformatf("v%0d.wv", idx), 32'(out_window_valid), 32'(e.wv));
    check($sformatf("v%0d.rdy", idx), 32'(in_byte_ready), 32'(e.rdy));
    check($sformatf("v%0d.eos", idx), 32'(out_eos), 32'(e.eos));
    check($sformatf("v%0d.ovr", idx), 32'(out_overrun), 32'(e.ovr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    //              fl vld byte   lst cns d      rdy win           cnt wv eos ovr
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 5'd0,  1, 32'h0000_0000, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 0, 5'd0,  1, 32'hA500_0000, 8,  0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hC3, 0, 0, 5'd0,  1, 32'hA5C3_0000, 16, 1, 0, 0));
    tbl.push_back(mk(1, 1, 8'h77, 0, 1, 5'd8,  1, 32'h0000_0000, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h11, 0, 0, 5'd0,  1, 32'h1100_0000, 8,  0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h22, 0, 0, 5'd0,  1, 32'h1122_0000, 16, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h33, 0, 0, 5'd0,  1, 32'h1122_3300, 24, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h44, 0, 0, 5'd0,  0, 32'h1122_3344, 32, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h55, 0, 0, 5'd0,  0, 32'h1122_3344, 32, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 5'd8,  1, 32'h2233_4400, 24, 1, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 5'd0,  1, 32'h0000_0000, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h11, 0, 0, 5'd0,  1, 32'h1100_0000, 8,  0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h22, 0, 0, 5'd0,  1, 32'h1122_0000, 16, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h33, 0, 0, 5'd0,  1, 32'h1122_3300, 24, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h55, 0, 1, 5'd8,  1, 32'h2233_5500, 24, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 5'd16, 1, 32'h5500_0000, 8,  0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 5'd4,  1, 32'h5500_0000, 8,  0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 5'd0,  1, 32'h5500_0000, 8,  0, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 5'd0,  1, 32'h0000_0000, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h11, 0, 0, 5'd0,  1, 32'h1100_0000, 8,  0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h22, 0, 0, 5'd0,  1, 32'h1122_0000, 16, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h33, 0, 1, 5'd17, 1, 32'h1122_3300, 24, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 5'd0,  1, 32'h0000_0000, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hAB, 0, 0, 5'd0,  1, 32'hAB00_0000, 8,  0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h80, 1, 0, 5'd0,  0, 32'hAB80_0000, 16, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 5'd16, 0, 32'h0000_0000, 0,  1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 5'd16, 0, 32'h0000_0000, 0,  1, 1, 0));
    tbl.push_back(mk(0, 1, 8'h12, 0, 0, 5'd0,  0, 32'h0000_0000, 0,  1, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 5'd0,  1, 32'h0000_0000, 0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h5C, 1, 0, 5'd0,  0, 32'h5C00_0000, 8,  1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 5'd4,  0, 32'hC000_0000, 4,  1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 5'd16, 0, 32'h0000_0000, 0,  1, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 5'd0,  1, 32'h0000_0000, 0,  0, 0, 0));

    // Reset held: outputs at reset values, no ready.
    idle_inputs();
    br_reset_n = 1'b0;
    repeat (2) @(posedge br_clk);
    #2;
    check("rst.rdy", 32'(in_byte_ready), 32'd0);
    check("rst.win", out_window, PADW);
    check("rst.cnt", 32'(out_cnt), 32'd0);
    check("rst.wv",  32'(out_window_valid), 32'd0);
    check("rst.eos", 32'(out_eos), 32'd0);
    check("rst.ovr", 32'(out_overrun), 32'd0);
    @(negedge br_clk);
    br_reset_n = 1'b1;
    #1;
    check("rst_rel.rdy", 32'(in_byte_ready), 32'd1);

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], i);
    end

    // Flush blocks ready combinationally in the same cycle.
    @(negedge br_clk);
    br_flush = 1'b1; in_byte_valid = 1'b1; in_byte = 8'h3C;
    #1;
    check("flush.rdy_comb", 32'(in_byte_ready), 32'd0);
    @(posedge br_clk);
    #1;
    idle_inputs();
    #1;
    check("flush.cnt", 32'(out_cnt), 32'd0);

    // Asynchronous reset in the middle of a tile.
    run_vec(mk(0, 1, 8'h9A, 0, 0, 5'd0, 1, 32'h9A00_0000, 8,  0, 0, 0), 100);
    run_vec(mk(0, 1, 8'hBC, 0, 0, 5'd0, 1, 32'h9ABC_0000, 16, 1, 0, 0), 101);
    @(negedge br_clk);
    #2;
    br_reset_n = 1'b0;
    #1;
    check("arst.cnt", 32'(out_cnt), 32'd0);
    check("arst.win", out_window, PADW);
    check("arst.wv",  32'(out_window_valid), 32'd0);
    check("arst.rdy", 32'(in_byte_ready), 32'd0);
    @(negedge br_clk);
    br_reset_n = 1'b1;
    #1;
    check("arst_rel.rdy", 32'(in_byte_ready), 32'd1);
    run_vec(mk(0, 1, 8'hE7, 0, 0, 5'd0, 1, 32'hE700_0000, 8, 0, 0, 0), 102);

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
    end
    total++;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
